// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM status encoding.
package cpu_types_pkg;

  localparam int unsigned WordWidth = 32;

  typedef logic [WordWidth-1:0] word_t;

  // RAM status reported back to the memory requester
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single RAM port between the icache and the dcache.
// The dcache has priority, but the icache cannot be starved: after
// STARVE_MAX consecutive dcache grants taken while the icache waits, the
// icache wins the next arbitration. Every access passes through IDLE, so
// there is always at least one bubble cycle between grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  // Consecutive dcache grants allowed while an icache request waits (max 7)
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  // icache side
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  // dcache side
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  // RAM side
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] IGRANT = 2'd2;

  // Starve counter is 3 bits wide; limit truncated to that width
  localparam logic [2:0] StarveLimit = 3'(STARVE_MAX);

  logic [1:0] state_q, state_d;
  logic [2:0] starve_q, starve_d;

  // State and starve counter; reset aborts any grant in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration, RAM drive and completion signalling
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    // Read data is a zero-latency pass-through to both caches
    iload    = ramload;
    dload    = ramload;

    case (state_q)
      IDLE: begin
        if (!iREN) begin
          starve_d = '0;
        end
        if (iREN && (!(dREN || dWEN) || (starve_q == StarveLimit))) begin
          state_d  = IGRANT;
          starve_d = '0;
        end else if (dREN || dWEN) begin
          state_d = DGRANT;
          // Only count dcache grants that actually made the icache wait
          if (iREN && (starve_q < StarveLimit)) begin
            starve_d = starve_q + 3'd1;
          end
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        // Write wins when both enables are raised
        ramREN   = dREN & ~dWEN;
        if (!(dREN || dWEN)) begin
          // Requester withdrew: drop the grant without signalling completion
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
        end
        // FREE/BUSY/ERROR hold the grant; ERROR is retried as-is
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into a
// queue, a negedge monitor pops and checks them whenever a wait drops.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;
  ramstate_t ramstate;

  typedef struct {
    bit    is_i;
    word_t addr;
    logic  ren;
    logic  wen;
    word_t store;
    word_t load;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic void push(input bit is_i, input word_t addr, input logic ren,
                               input logic wen, input word_t store, input word_t load);
    exp_t e;
    e.is_i  = is_i;
    e.addr  = addr;
    e.ren   = ren;
    e.wen   = wen;
    e.store = store;
    e.load  = load;
    exp_q.push_back(e);
  endfunction

  // Non-completion cycle: RAM drive as given, both waits high, loads pass through
  task automatic expect_ram(input string tag, input logic ren, input logic wen,
                            input word_t addr, input word_t store);
    chk1({tag, "_ren"}, ramREN, ren);
    chk1({tag, "_wen"}, ramWEN, wen);
    chk({tag, "_addr"}, ramaddr, addr);
    chk({tag, "_store"}, ramstore, store);
    chk1({tag, "_iwait"}, iwait, 1'b1);
    chk1({tag, "_dwait"}, dwait, 1'b1);
    chk({tag, "_dload"}, dload, ramload);
    chk({tag, "_iload"}, iload, ramload);
  endtask

  task automatic wait_neg();
    @(negedge CLK);
  endtask

  task automatic wait_pos();
    @(posedge CLK);
    #1;
  endtask

  // Completion monitor
  always @(negedge CLK) begin
    if (!RST && (!iwait || !dwait)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_cpl: got iwait=%b dwait=%b want both 1", iwait, dwait);
      end else begin
        mon_e = exp_q.pop_front();
        chk1("cpl_iwait", iwait, !mon_e.is_i);
        chk1("cpl_dwait", dwait, mon_e.is_i);
        chk("cpl_addr", ramaddr, mon_e.addr);
        chk1("cpl_ren", ramREN, mon_e.ren);
        chk1("cpl_wen", ramWEN, mon_e.wen);
        chk("cpl_store", ramstore, mon_e.store);
        chk("cpl_load", mon_e.is_i ? iload : dload, mon_e.load);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = 32'h1234_5678;
    ramstate = FREE;

    // Reset state, with requests raised while reset is held
    #2;
    expect_ram("rst0", 1'b0, 1'b0, 32'h0, 32'h0);
    iREN = 1'b1; dREN = 1'b1;
    wait_neg();
    expect_ram("rst1", 1'b0, 1'b0, 32'h0, 32'h0);
    iREN = 1'b0; dREN = 1'b0;
    RST = 1'b0;
    wait_pos();

    // dcache read, two BUSY cycles then ACCESS
    dREN = 1'b1; daddr = 32'h100; dstore = '0; ramstate = BUSY; ramload = 32'hDEAD_BEEF;
    push(1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    wait_neg(); expect_ram("r21_bubble", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    repeat (2) begin
      wait_neg(); expect_ram("r21_busy", 1'b1, 1'b0, 32'h100, 32'h0); wait_pos();
    end
    ramstate = ACCESS;
    wait_neg(); wait_pos();
    dREN = 1'b0; ramstate = FREE;
    wait_neg(); expect_ram("r21_after", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();

    // dcache write, then a second write proving the IDLE bubble
    dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5; ramstate = BUSY; ramload = 32'h11;
    push(1'b0, 32'h3100, 1'b0, 1'b1, 32'h5, 32'h11);
    wait_neg(); expect_ram("r22_bubble", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    wait_neg(); expect_ram("r22_busy", 1'b0, 1'b1, 32'h3100, 32'h5); wait_pos();
    ramstate = ACCESS;
    wait_neg(); wait_pos();
    dstore = 32'h6;
    push(1'b0, 32'h3100, 1'b0, 1'b1, 32'h6, 32'h11);
    wait_neg(); expect_ram("r22_idle", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    wait_neg(); wait_pos();
    dWEN = 1'b0; ramstate = FREE;
    wait_neg(); expect_ram("r22_after", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();

    // Both caches requesting, RAM always ready: 4 dcache then 1 icache, twice
    iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h200; dstore = '0;
    ramstate = ACCESS; ramload = 32'hA5A5_0000;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) push(1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 32'hA5A5_0000);
      push(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 32'hA5A5_0000);
    end
    repeat (20) wait_pos();
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    chk("r23_drained", 32'(exp_q.size()), 32'h0);
    wait_neg(); expect_ram("r23_after", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();

    // ERROR is retried with the request held unchanged
    dREN = 1'b1; daddr = 32'h44; ramstate = ERROR; ramload = 32'h24;
    push(1'b0, 32'h44, 1'b1, 1'b0, 32'h0, 32'h24);
    wait_neg(); expect_ram("r24_bubble", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    repeat (3) begin
      wait_neg(); expect_ram("r24_error", 1'b1, 1'b0, 32'h44, 32'h0); wait_pos();
    end
    ramstate = ACCESS;
    wait_neg(); wait_pos();
    dREN = 1'b0; ramstate = FREE;
    wait_neg(); expect_ram("r24_after", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();

    // Reset pulsed during an icache grant
    iREN = 1'b1; iaddr = 32'h800; ramstate = BUSY; ramload = 32'h25;
    wait_neg(); expect_ram("r25_bubble0", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    wait_neg(); expect_ram("r25_grant", 1'b1, 1'b0, 32'h800, 32'h0);
    #2; RST = 1'b1;
    #1; expect_ram("r25_rst", 1'b0, 1'b0, 32'h0, 32'h0);
    wait_pos();
    RST = 1'b0; ramload = 32'h2525;
    push(1'b1, 32'h800, 1'b1, 1'b0, 32'h0, 32'h2525);
    wait_neg(); expect_ram("r25_bubble1", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    wait_neg(); expect_ram("r25_busy", 1'b1, 1'b0, 32'h800, 32'h0); wait_pos();
    ramstate = ACCESS;
    wait_neg(); wait_pos();
    iREN = 1'b0; ramstate = FREE;
    wait_neg(); expect_ram("r25_after", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();

    // dcache withdraws mid-grant; write wins while both enables are set
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h60; dstore = 32'h77; ramstate = BUSY;
    ramload = 32'h26;
    wait_neg(); expect_ram("r26_bubble", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    wait_neg(); expect_ram("r26_grant", 1'b0, 1'b1, 32'h60, 32'h77); wait_pos();
    dREN = 1'b0; dWEN = 1'b0; ramstate = ACCESS;
    wait_neg();
    chk1("r26_wd_ren", ramREN, 1'b0);
    chk1("r26_wd_wen", ramWEN, 1'b0);
    chk1("r26_wd_dwait", dwait, 1'b1);
    wait_pos();
    // Re-request: must see an IDLE cycle before the new grant completes
    dWEN = 1'b1; dstore = 32'h88;
    push(1'b0, 32'h60, 1'b0, 1'b1, 32'h88, 32'h26);
    wait_neg(); expect_ram("r26_idle", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();
    wait_neg(); wait_pos();
    dWEN = 1'b0; ramstate = FREE;
    wait_neg(); expect_ram("r26_after", 1'b0, 1'b0, 32'h0, 32'h0); wait_pos();

    repeat (3) wait_pos();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive dcache grants allowed while an icache request waits.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high; port list:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache stall; 0 = access completes this cycle
- iload  out  32  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; 0 = access completes this cycle
- dload  out  32  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Function
REQ-003 SHALL implement FSM states IDLE, DGRANT, IGRANT; one access per grant.
REQ-004 IDLE -> IGRANT when iREN=1 and (dREN|dWEN)=0.
REQ-005 IDLE -> IGRANT when iREN=1 and starve count = STARVE_MAX, regardless of dcache requests.
REQ-006 Otherwise IDLE -> DGRANT when dREN|dWEN = 1; otherwise stay in IDLE.
REQ-007 In DGRANT: drive ramaddr=daddr and ramstore=dstore; drive ramWEN=dWEN; drive ramREN=dREN&~dWEN. Write wins when both are set.
REQ-008 In IGRANT: drive ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-009 In IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-010 Completion occurs when ramstate=ACCESS in a grant state.
- The granted port's wait=0 in that same cycle, combinationally.
- FSM returns to IDLE next edge.
- Each access costs at least one IDLE bubble cycle.
REQ-011 iwait=0 only in IGRANT with ramstate=ACCESS; dwait=0 only in DGRANT with ramstate=ACCESS; otherwise both 1.
REQ-012 iload=ramload and dload=ramload at all times, pass-through with zero latency.
REQ-013 ramstate FREE, BUSY or ERROR in a grant state: hold grant and keep driving the same request (ERROR = retry); wait stays 1.
REQ-014 Requester withdraws mid-grant (DGRANT with dREN=dWEN=0, or IGRANT with iREN=0): ram enables drop that cycle; FSM -> IDLE next edge; no completion signalled.
REQ-015 Starve count is 3 bits, saturating at STARVE_MAX.
- Increments on each IDLE->DGRANT transition taken while iREN=1.
- Clears on IDLE->IGRANT.
- Clears in IDLE when iREN=0.
REQ-016 Address and data ports are not registered; the requester SHALL hold them stable until its wait=0.

Reset
REQ-017 RST=1 SHALL immediately force FSM=IDLE and starve count=0.
- Outputs then read: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=ramload.
REQ-018 Reset asserted mid-grant SHALL abort the access with no completion; after release, arbitration restarts from IDLE.

Structure
REQ-019 ramstate_t (FREE/BUSY/ACCESS/ERROR) and word_t SHALL come from cpu_types_pkg; the arbiter state enum stays local.
REQ-020 Single module, no sub-modules; one always_ff for state and counter, one always_comb for next-state and outputs.

Verification
REQ-021 dREN=1, daddr=0x100, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100; dwait=0 on cycle 3 with dload=0xDEADBEEF; iwait stays 1.
REQ-022 dWEN=1, daddr=0x3100, dstore=0x5 -> ramWEN=1, ramREN=0, ramstore=0x5 until ACCESS; then dwait=0 for one cycle and FSM back to IDLE.
REQ-023 iREN=1 and dREN=1 held continuously, RAM always ACCESS -> 4 dcache completions, then 1 icache completion (iaddr forwarded), pattern repeating.
REQ-024 DGRANT with ramstate=ERROR for 3 cycles, then ACCESS -> request driven unchanged for 4 cycles; dwait=0 only in the 4th.
REQ-025 RST pulsed during IGRANT with BUSY; afterwards iREN=1 held -> outputs at reset values immediately; new IGRANT starts from IDLE; iwait=0 only on the next ACCESS.
REQ-026 DGRANT, then dREN and dWEN both dropped before ACCESS -> ramREN=ramWEN=0 that cycle; IDLE next cycle; dwait never 0.
